// File: rtl/nn_layer_sequencer.sv
// Batch sequencer for the NN inference datapath: steps each sample through the hidden
// layers and the output calculation via go/done handshakes, with watchdog and abort.
module nn_layer_sequencer #(
    parameter int NUM_LAYERS  = 2,
    parameter int NUM_SAMPLES = 750,
    parameter int TIMEOUT     = 1023,
    parameter int LW          = (NUM_LAYERS  > 1) ? $clog2(NUM_LAYERS)  : 1,
    parameter int SW          = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_layer_done,
    input  logic          i_calc_done,
    output logic          o_ready,
    output logic          o_ld_input,
    output logic          o_layer_go,
    output logic [LW-1:0] o_layer_sel,
    output logic          o_hidden,
    output logic          o_calc_go,
    output logic [SW-1:0] o_sample_idx,
    output logic          o_sample_done,
    output logic          o_batch_done,
    output logic          o_error
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] LAST_LAYER  = LW'(NUM_LAYERS - 1);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(NUM_SAMPLES - 1);
    localparam logic [WW-1:0] WDOG_LAST   = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WDOG_SAT    = WW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_L_GO,
        S_L_WAIT,
        S_C_GO,
        S_C_WAIT,
        S_NEXT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [LW-1:0] r_layer_sel;
    logic [LW-1:0] w_layer_sel;
    logic [SW-1:0] r_sample_idx;
    logic [SW-1:0] w_sample_idx;
    logic [WW-1:0] r_wdog;
    logic [WW-1:0] w_wdog;
    logic          r_error;
    logic          w_error;
    logic          r_ready;
    logic          r_ld_input;
    logic          r_layer_go;
    logic          r_hidden;
    logic          r_calc_go;
    logic          r_sample_done;
    logic          r_batch_done;

    // Abort overrides everything; a watchdog expiry abandons the batch like an abort but flags error.
    always_comb begin
        w_next       = r_state;
        w_layer_sel  = r_layer_sel;
        w_sample_idx = r_sample_idx;
        w_wdog       = r_wdog;
        w_error      = r_error;
        if (i_abort) begin
            w_next       = S_IDLE;
            w_layer_sel  = '0;
            w_sample_idx = '0;
            w_wdog       = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_next       = S_LOAD;
                        w_sample_idx = '0;
                        w_layer_sel  = '0;
                        w_error      = 1'b0;
                    end
                end
                S_LOAD: w_next = S_L_GO;
                S_L_GO: begin
                    w_next = S_L_WAIT;
                    w_wdog = '0;
                end
                S_L_WAIT: begin
                    if (i_layer_done) begin
                        if (r_layer_sel == LAST_LAYER) begin
                            w_next      = S_C_GO;
                            w_layer_sel = '0;
                        end else begin
                            w_next      = S_L_GO;
                            w_layer_sel = r_layer_sel + LW'(1);
                        end
                    end else if (r_wdog == WDOG_LAST) begin
                        w_next       = S_IDLE;
                        w_error      = 1'b1;
                        w_sample_idx = '0;
                        w_layer_sel  = '0;
                        w_wdog       = WDOG_SAT;
                    end else begin
                        w_wdog = r_wdog + WW'(1);
                    end
                end
                S_C_GO: begin
                    w_next = S_C_WAIT;
                    w_wdog = '0;
                end
                S_C_WAIT: begin
                    if (i_calc_done) begin
                        w_next = S_NEXT;
                    end else if (r_wdog == WDOG_LAST) begin
                        w_next       = S_IDLE;
                        w_error      = 1'b1;
                        w_sample_idx = '0;
                        w_layer_sel  = '0;
                        w_wdog       = WDOG_SAT;
                    end else begin
                        w_wdog = r_wdog + WW'(1);
                    end
                end
                S_NEXT: begin
                    if (r_sample_idx == LAST_SAMPLE) begin
                        w_next       = S_IDLE;
                        w_sample_idx = '0;
                    end else begin
                        w_next       = S_LOAD;
                        w_sample_idx = r_sample_idx + SW'(1);
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_layer_sel   <= '0;
            r_sample_idx  <= '0;
            r_wdog        <= '0;
            r_error       <= 1'b0;
            r_ready       <= 1'b1;
            r_ld_input    <= 1'b0;
            r_layer_go    <= 1'b0;
            r_hidden      <= 1'b0;
            r_calc_go     <= 1'b0;
            r_sample_done <= 1'b0;
            r_batch_done  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_layer_sel   <= w_layer_sel;
            r_sample_idx  <= w_sample_idx;
            r_wdog        <= w_wdog;
            r_error       <= w_error;
            r_ready       <= (w_next == S_IDLE);
            r_ld_input    <= (w_next == S_LOAD);
            r_layer_go    <= (w_next == S_L_GO);
            r_hidden      <= (w_next == S_L_GO) || (w_next == S_L_WAIT);
            r_calc_go     <= (w_next == S_C_GO);
            r_sample_done <= (w_next == S_NEXT);
            r_batch_done  <= (w_next == S_NEXT) && (w_sample_idx == LAST_SAMPLE);
        end
    end

    assign o_ready       = r_ready;
    assign o_ld_input    = r_ld_input;
    assign o_layer_go    = r_layer_go;
    assign o_layer_sel   = r_layer_sel;
    assign o_hidden      = r_hidden;
    assign o_calc_go     = r_calc_go;
    assign o_sample_idx  = r_sample_idx;
    assign o_sample_done = r_sample_done;
    assign o_batch_done  = r_batch_done;
    assign o_error       = r_error;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer: directed scenarios plus random traffic,
// compared every cycle against a step-schedule reference model.
module tb_nn_layer_sequencer;

    localparam int NL = 2;
    localparam int NS = 3;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, layer_done, calc_done;
    logic       ready, ld_input, layer_go, hidden, calc_go;
    logic       sample_done, batch_done, error;
    logic [0:0] layer_sel;
    logic [1:0] sample_idx;

    logic       d2_start, d2_abort, d2_layer_done, d2_calc_done;
    logic       d2_ready, d2_ld_input, d2_layer_go, d2_hidden, d2_calc_go;
    logic       d2_sample_done, d2_batch_done, d2_error;
    logic [0:0] d2_layer_sel;
    logic [0:0] d2_sample_idx;

    int checks = 0;
    int errors = 0;

    // Reference model: a sample is a schedule of steps 0..2*NL+3
    // (load, go/wait per layer, calc go, calc wait, sample done).
    bit m_busy;
    int m_step;
    int m_sample;
    int m_waited;
    bit m_error;

    int cnt_lgo, cnt_cgo, cnt_ld, cnt_sd, cnt_bd;

    always #5 clk = ~clk;

    nn_layer_sequencer #(.NUM_LAYERS(NL), .NUM_SAMPLES(NS), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_layer_done(layer_done), .i_calc_done(calc_done),
        .o_ready(ready), .o_ld_input(ld_input), .o_layer_go(layer_go),
        .o_layer_sel(layer_sel), .o_hidden(hidden), .o_calc_go(calc_go),
        .o_sample_idx(sample_idx), .o_sample_done(sample_done),
        .o_batch_done(batch_done), .o_error(error)
    );

    nn_layer_sequencer #(.NUM_LAYERS(1), .NUM_SAMPLES(1), .TIMEOUT(TO)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(d2_start), .i_abort(d2_abort),
        .i_layer_done(d2_layer_done), .i_calc_done(d2_calc_done),
        .o_ready(d2_ready), .o_ld_input(d2_ld_input), .o_layer_go(d2_layer_go),
        .o_layer_sel(d2_layer_sel), .o_hidden(d2_hidden), .o_calc_go(d2_calc_go),
        .o_sample_idx(d2_sample_idx), .o_sample_done(d2_sample_done),
        .o_batch_done(d2_batch_done), .o_error(d2_error)
    );

    function automatic bit isWait(int s);
        return (s >= 1 && s <= 2*NL && ((s - 1) % 2) == 1) || (s == 2*NL + 2);
    endfunction

    task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_busy = 0; m_step = 0; m_sample = 0; m_waited = 0; m_error = 0;
    endtask

    task automatic clearCounts();
        cnt_lgo = 0; cnt_cgo = 0; cnt_ld = 0; cnt_sd = 0; cnt_bd = 0;
    endtask

    task automatic modelStep(bit st, bit ab, bit ld, bit cd);
        bit dn;
        if (ab) begin
            m_busy = 0; m_step = 0; m_sample = 0; m_waited = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_step = 0; m_sample = 0; m_error = 0;
            end
        end else if (isWait(m_step)) begin
            dn = (m_step == 2*NL + 2) ? cd : ld;
            if (dn) begin
                m_step++; m_waited = 0;
            end else if (m_waited + 1 >= TO) begin
                m_error = 1; m_busy = 0; m_step = 0; m_sample = 0;
            end else begin
                m_waited++;
            end
        end else if (m_step == 2*NL + 3) begin
            if (m_sample == NS - 1) begin
                m_busy = 0; m_sample = 0;
            end else begin
                m_sample++;
            end
            m_step = 0;
        end else begin
            m_step++; m_waited = 0;
        end
    endtask

    task automatic checkOutput();
        bit inL;
        bit nx;
        inL = m_busy && m_step >= 1 && m_step <= 2*NL;
        nx  = m_busy && m_step == 2*NL + 3;
        checkVal("ready",       ready,       32'(!m_busy));
        checkVal("ld_input",    ld_input,    32'(m_busy && m_step == 0));
        checkVal("layer_go",    layer_go,    32'(inL && ((m_step - 1) % 2) == 0));
        checkVal("hidden",      hidden,      32'(inL));
        checkVal("layer_sel",   layer_sel,   inL ? 32'((m_step - 1) / 2) : 32'd0);
        checkVal("calc_go",     calc_go,     32'(m_busy && m_step == 2*NL + 1));
        checkVal("sample_idx",  sample_idx,  32'(m_sample));
        checkVal("sample_done", sample_done, 32'(nx));
        checkVal("batch_done",  batch_done,  32'(nx && m_sample == NS - 1));
        checkVal("error",       error,       32'(m_error));
        if (layer_go === 1'b1)    cnt_lgo++;
        if (calc_go === 1'b1)     cnt_cgo++;
        if (ld_input === 1'b1)    cnt_ld++;
        if (sample_done === 1'b1) cnt_sd++;
        if (batch_done === 1'b1)  cnt_bd++;
    endtask

    // One clock: check current outputs, drive inputs, then advance the model on the edge.
    task automatic applyStimulus(bit st, bit ab, bit ld, bit cd);
        @(negedge clk);
        checkOutput();
        start = st; abort = ab; layer_done = ld; calc_done = cd;
        @(posedge clk);
        modelStep(st, ab, ld, cd);
    endtask

    task automatic boundFail(string tag);
        errors++;
        $error("[TB] FAIL %s observed=timeout expected=reached", tag);
    endtask

    initial begin
        int n;
        int stall;
        int w;
        int sdIdx, n2sd, n2co;
        rst_n = 1'b0; start = 0; abort = 0; layer_done = 0; calc_done = 0;
        d2_start = 0; d2_abort = 0; d2_layer_done = 0; d2_calc_done = 0;
        modelReset();
        clearCounts();
        #12;
        $display("[TB] reset values");
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] nominal batch");
        applyStimulus(1, 0, 1, 1);
        clearCounts();
        for (int i = 0; i < NS * (2*NL + 4); i++) applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0);
        checkVal("nom_layer_go_cnt", cnt_lgo, 6);
        checkVal("nom_calc_go_cnt",  cnt_cgo, 3);
        checkVal("nom_ld_input_cnt", cnt_ld,  3);
        checkVal("nom_sample_done",  cnt_sd,  3);
        checkVal("nom_batch_done",   cnt_bd,  1);

        $display("[TB] stalled layer");
        applyStimulus(1, 0, 0, 0);
        stall = 0; n = 0;
        while (m_busy && n < 100) begin
            if (m_sample == 1 && m_step == 4 && stall < 5) begin
                stall++;
                applyStimulus(0, 0, 0, 1);
            end else begin
                applyStimulus(0, 0, 1, 1);
            end
            n++;
        end
        if (n >= 100) boundFail("stall_bound");
        #1;
        checkVal("stall_error", error, 0);
        checkVal("stall_len",   stall, 5);

        $display("[TB] timeout");
        clearCounts();
        applyStimulus(1, 0, 1, 0);
        n = 0;
        while (m_busy && n < 100) begin
            applyStimulus(0, 0, 1, 0);
            n++;
        end
        if (n >= 100) boundFail("timeout_bound");
        #1;
        checkVal("timeout_error",  error,      1);
        checkVal("timeout_ready",  ready,      1);
        checkVal("timeout_idx",    sample_idx, 0);
        checkVal("timeout_nobd",   cnt_bd,     0);
        applyStimulus(1, 0, 1, 1);
        #1;
        checkVal("restart_clears_error", error, 0);

        $display("[TB] abort");
        n = 0;
        while (!m_busy || !(m_sample == 2 && m_step == 2)) begin
            if (n >= 100) break;
            applyStimulus(!m_busy, 0, 1, 1);
            n++;
        end
        if (n >= 100) boundFail("abort_bound");
        clearCounts();
        applyStimulus(0, 1, 0, 0);
        #1;
        checkVal("abort_ready",   ready,      1);
        checkVal("abort_idx",     sample_idx, 0);
        applyStimulus(1, 0, 1, 1);
        checkVal("abort_nosd",    cnt_sd,     0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1);

        $display("[TB] done at watchdog limit, start mid-batch");
        n = 0;
        while (m_busy && n < 100) begin
            applyStimulus(0, 0, 1, 1);
            n++;
        end
        clearCounts();
        applyStimulus(1, 0, 1, 1);
        w = 0; n = 0;
        while (m_busy && n < 100) begin
            if (m_sample == 0 && m_step == 2 && w < TO - 1) begin
                w++;
                applyStimulus(1, 0, 0, 1);
            end else begin
                applyStimulus(1, 0, 1, 1);
            end
            n++;
        end
        if (n >= 100) boundFail("limit_bound");
        #1;
        checkVal("limit_no_error", error,  0);
        checkVal("limit_bd_once",  cnt_bd, 1);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40);
        end

        $display("[TB] async reset in C_WAIT");
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0);
        n = 0;
        while (!(m_busy && m_sample == 1 && m_step == 2*NL + 2) && n < 100) begin
            applyStimulus(0, 0, 1, m_step == 2*NL + 2);
            n++;
        end
        if (n >= 100) boundFail("areset_bound");
        #2;
        checkVal("pre_reset_busy", ready, 0);
        rst_n = 1'b0;
        #1;
        checkVal("areset_ready",       ready,       1);
        checkVal("areset_ld_input",    ld_input,    0);
        checkVal("areset_layer_go",    layer_go,    0);
        checkVal("areset_hidden",      hidden,      0);
        checkVal("areset_calc_go",     calc_go,     0);
        checkVal("areset_layer_sel",   layer_sel,   0);
        checkVal("areset_sample_idx",  sample_idx,  0);
        checkVal("areset_sample_done", sample_done, 0);
        checkVal("areset_batch_done",  batch_done,  0);
        checkVal("areset_error",       error,       0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 1);

        $display("[TB] single layer, single sample");
        sdIdx = -1; n2sd = 0; n2co = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkVal("n1_layer_sel", d2_layer_sel, 0);
                if (d2_sample_done === 1'b1) begin
                    n2sd++;
                    sdIdx = i;
                    if (d2_batch_done === 1'b1) n2co++;
                end
            end
            d2_start = (i == 0); d2_layer_done = 1'b1; d2_calc_done = 1'b1;
        end
        checkVal("n1_sample_done_cnt", n2sd,  1);
        checkVal("n1_coincident_bd",   n2co,  1);
        checkVal("n1_sample_cycles",   sdIdx, 6);
        checkVal("n1_ready_after",     d2_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
